imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle RISC-V core's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive word-aligned byte addresses starting at 0x00. Holds the core in reset until loading completes, then releases it so execution starts from PC 0x00.

## Interface
- `ADDR_W`, 8: byte-address width of instruction memory.
- `MAX_WORDS`, 64: largest accepted program length in words. Must satisfy `MAX_WORDS*4 <= 2**ADDR_W`.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a load; ignored outside IDLE/RUN/ERROR.
- `in_valid`  in  1  byte-stream valid.
- `in_ready`  out  1  loader can accept a byte.
- `in_byte`  in  8  stream byte.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  byte address of the word written (0, 4, 8, …).
- `imem_wdata`  out  32  word written.
- `core_reset`  out  1  reset to the core; high except in RUN.
- `done`  out  1  high in RUN.
- `err`  out  1  high in ERROR.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 data bytes (byte 0 = bits 7:0), then a checksum byte if configured.
- A byte transfers on a rising edge with `in_valid && in_ready`.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, RUN, ERROR.
- IDLE: `in_ready`=0. On `start` -> LEN_LO.
- LEN_LO/LEN_HI: accept one byte each. After LEN_HI: N=0 -> RUN (or CHK); N>MAX_WORDS -> ERROR; otherwise -> DATA.
- DATA: accept bytes into a shift register and a 2-bit byte counter. The 4th byte -> WRITE.
- WRITE: one cycle. `imem_we`=1, `in_ready`=0, and `imem_addr` = word index × 4. Word index increments. On the last word -> RUN (or CHK); otherwise -> DATA.
- RUN: `core_reset`=0 and `done`=1. A `start` pulse -> LEN_LO and reasserts `core_reset` that same edge.
- ERROR: `err`=1, `core_reset`=1, `in_ready`=0. Exit only via `start` (-> LEN_LO) or `reset`.
- `in_valid` held low stalls any receiving state indefinitely; no timeout.
- Address arithmetic is modulo 2^ADDR_W. Wrap cannot occur given the parameter constraint.

## Timing
- Reset values: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_reset`=1, `done`=0, `err`=0. State is IDLE; word index and byte counter are 0.
- All outputs are registered. `in_ready` rises the cycle after `start` is sampled.
- The 4th data byte is accepted on edge k. `imem_we`/`imem_addr`/`imem_wdata` are valid during cycle k+1. The next byte can be accepted at edge k+2 at the earliest.
- Best-case throughput is 5 cycles per word.
- `core_reset` falls the cycle after the final WRITE (or after the LEN_HI/CHK edge when N=0).
- `reset` mid-load returns to IDLE next edge. Words already written remain in memory. No further `imem_we` is issued.
- `start` while in LEN_LO..CHK is ignored.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: CHK state accepts one byte after the last word (or after LEN_HI when N=0).
  - The checksum byte must equal the XOR of all preceding stream bytes (length bytes included).
  - Match -> RUN; mismatch -> ERROR.
- Undefined: there is no CHK state. The final WRITE goes straight to RUN.

## Structure
- `imem_loader_pkg` contains:
  - the state encoding (localparams, 3 bits);
  - the length-field width (16);
  - the checksum XOR function.
- Sub-module `byte_assembler` holds the 32-bit shift register, the 2-bit byte counter, and the `word_full` flag. The FSM, address counter and checksum accumulator stay in the top.

## Test plan
- Stream 02 00 93 00 50 00 13 01 A0 00 after `start` -> write addr 0x00 data 0x00500093, then write addr 0x04 data 0x00A00113. `core_reset` falls the cycle after the second write and `done`=1.
- Length 0x0041 (65) -> ERROR. `err`=1, `in_ready`=0, no `imem_we`; a subsequent `start` returns to LEN_LO.
- Random `in_valid` gaps during a 4-word load -> identical writes. `in_ready` is 0 in every WRITE cycle.
- `reset` after 6 data bytes -> IDLE next edge. Exactly one write (addr 0x00) has occurred and `core_reset`=1.
- In RUN, `start` then stream 01 00 33 85 20 00 -> `core_reset` reasserts, then one write at addr 0x00 of 0x00208533, then RUN.
- With `IMEM_LOADER_CHECKSUM_EN`: stream 01 00 93 00 50 00 with checksum C2 -> RUN. The same stream with checksum C3 -> ERROR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned StateW = 3;
  // Width of the little-endian word-count field at the head of the stream.
  localparam int unsigned LenW   = 16;

  typedef enum logic [StateW-1:0] {
    StIdle  = 3'd0,
    StLenLo = 3'd1,
    StLenHi = 3'd2,
    StData  = 3'd3,
    StWrite = 3'd4,
    StChk   = 3'd5,
    StRun   = 3'd6,
    StError = 3'd7
  } state_e;

  // Running checksum: XOR of every stream byte seen so far.
  function automatic logic [7:0] chk_xor(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs four stream bytes, least significant first, into a 32-bit word.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;

  // Shift register and byte counter; new bytes enter at the top so byte 0 ends in bits 7:0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en) begin
      word_q <= {in_byte, word_q[31:8]};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  // Flags the edge on which the fourth byte of a word is taken.
  always_comb begin
    word_full = shift_en && (cnt_q == 2'd3);
  end

  assign word = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> little-endian words -> instruction memory, then releases the core.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds a trailing XOR checksum byte).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e StAfterLoad = StChk;
`else
  localparam state_e StAfterLoad = StRun;
`endif

  state_e            state_q, state_d;
  logic [LenW-1:0]   n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_ready_q, we_q, core_reset_q, done_q, err_q;
  logic              accept, asm_clear, asm_shift, word_full, last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign accept    = in_valid && in_ready_q;
  assign asm_shift = accept && (state_q == StData);
  // addr_q still holds the address of the word being written during WRITE.
  assign last_word = (LenW'(addr_q >> 2) + LenW'(1)) == n_q;

  imem_loader_byte_assembler u_byte_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .in_byte   (in_byte),
    .word      (imem_wdata),
    .word_full (word_full)
  );

  // Next-state logic for the load sequence, address counter and checksum.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    addr_d    = addr_q;
    asm_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    if (accept && (state_q != StChk)) csum_d = chk_xor(csum_q, in_byte);
`endif
    case (state_q)
      StLenLo: if (accept) begin
        n_d[7:0] = in_byte;
        state_d  = StLenHi;
      end
      StLenHi: if (accept) begin
        n_d[15:8] = in_byte;
        if (n_d == '0)                   state_d = StAfterLoad;
        else if (n_d > LenW'(MAX_WORDS)) state_d = StError;
        else                             state_d = StData;
      end
      StData: if (word_full) state_d = StWrite;
      StWrite: begin
        addr_d  = addr_q + ADDR_W'(4);
        state_d = last_word ? StAfterLoad : StData;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: if (accept) state_d = (in_byte == csum_q) ? StRun : StError;
`endif
      StIdle, StRun, StError: if (start) begin
        state_d   = StLenLo;
        addr_d    = '0;
        asm_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = '0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs, the latter decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      n_q          <= '0;
      addr_q       <= '0;
      in_ready_q   <= 1'b0;
      we_q         <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      addr_q       <= addr_d;
      in_ready_q   <= state_d inside {StLenLo, StLenHi, StData, StChk};
      we_q         <= state_d == StWrite;
      core_reset_q <= state_d != StRun;
      done_q       <= state_d == StRun;
      err_q        <= state_d == StError;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader.
module tb_imem_loader;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned MAX_WORDS = 64;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [7:0]        in_byte;
  logic              in_ready, imem_we, core_reset, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W+31:0] wq[$];   // expected writes {addr, data}
  logic [31:0]        prog[$]; // program words for the next load

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      chk("ready_low_in_write", 64'(in_ready), 64'd0);
      if (wq.size() == 0) begin
        chk("unexpected_write", 64'({imem_addr, imem_wdata}), 64'd0);
        if ({imem_addr, imem_wdata} == '0) chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        logic [ADDR_W+31:0] e;
        e = wq.pop_front();
        chk("write_addr", 64'(imem_addr), 64'(e[ADDR_W+31:32]));
        chk("write_data", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ready_after_start", 64'(in_ready), 64'd1);
    chk("core_reset_after_start", 64'(core_reset), 64'd1);
  endtask

  // Offer one byte after a random idle gap; returns at the negedge after it transfers.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int waited = 0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 100) begin
        chk("handshake_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_byte  = $urandom_range(0, 255);
  endtask

  // Stream a whole load of prog[0..n-1]; the model predicts writes and the final outcome.
  task automatic do_load(input int n, input bit do_start, input int gap_max, input bit bad_chk);
    logic [7:0]  cs = 8'h00;
    logic [15:0] len = 16'(n);
    bit          ok = (n <= int'(MAX_WORDS));
    bit          exp_done, exp_err;
    if (do_start) pulse_start();
    if (ok) for (int i = 0; i < n; i++) wq.push_back({ADDR_W'(i * 4), prog[i]});
    send_byte(len[7:0], gap_max);
    cs ^= len[7:0];
    send_byte(len[15:8], gap_max);
    cs ^= len[15:8];
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          logic [7:0] b;
          b = prog[i][8*k +: 8];
          send_byte(b, gap_max);
          cs ^= b;
        end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (ok) send_byte(bad_chk ? (cs ^ 8'h01) : cs, gap_max);
    exp_done = ok && !bad_chk;
    exp_err  = !exp_done;
`else
    exp_done = ok;
    exp_err  = !ok;
    if (bad_chk) exp_err = !ok;
    if (ok && n > 0) begin
      chk("done_low_during_write", 64'(done), 64'd0);
      @(negedge clk);
    end
`endif
    chk("final_done", 64'(done), 64'(exp_done));
    chk("final_err", 64'(err), 64'(exp_err));
    chk("final_core_reset", 64'(core_reset), 64'(!exp_done));
    chk("final_ready", 64'(in_ready), 64'd0);
    chk("writes_drained", 64'(wq.size()), 64'd0);
  endtask

  task automatic rand_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom());
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Two-word directed program.
    prog = '{32'h00500093, 32'h00A00113};
    do_load(2, 1'b1, 0, 1'b0);

    // Oversized length goes to ERROR and stays there without writing.
    do_load(65, 1'b1, 1, 1'b0);
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    chk("err_holds", 64'(err), 64'd1);
    chk("err_ready_low", 64'(in_ready), 64'd0);

    // Start from ERROR, four random words with random valid gaps.
    rand_prog(4);
    do_load(4, 1'b1, 4, 1'b0);

    // Restart from RUN with a one-word program.
    prog = '{32'h00208533};
    do_load(1, 1'b1, 0, 1'b0);

    // Reset after six data bytes: only the first word lands.
    rand_prog(4);
    pulse_start();
    wq.push_back({ADDR_W'(0), prog[0]});
    send_byte(8'h04, 1);
    send_byte(8'h00, 1);
    for (int j = 0; j < 6; j++) begin
      logic [31:0] w;
      w = prog[j / 4];
      send_byte(w[8*(j%4) +: 8], 1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_ready", 64'(in_ready), 64'd0);
    chk("midrst_core_reset", 64'(core_reset), 64'd1);
    chk("midrst_done", 64'(done), 64'd0);
    repeat (4) @(negedge clk);
    chk("midrst_writes", 64'(wq.size()), 64'd0);
    chk("midrst_no_we", 64'(imem_we), 64'd0);

    // Boundary lengths and random loads.
    rand_prog(0);
    do_load(0, 1'b1, 0, 1'b0);
    rand_prog(MAX_WORDS);
    do_load(MAX_WORDS, 1'b1, 0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 6);
      rand_prog(n);
      do_load(n, 1'b1, 3, 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum 0xC2 is good, 0xC3 (bad_chk flips bit 0) is rejected.
    prog = '{32'h00500093};
    do_load(1, 1'b1, 0, 1'b0);
    do_load(1, 1'b1, 0, 1'b1);
    rand_prog(3);
    do_load(3, 1'b1, 2, 1'b1);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
